if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

- Fetch stage that produces `PC_F`, `PCPlus4_F` and `Instr_F` for the IF/ID pipeline register.
- Owns the fetch PC and drives a req/ack instruction-memory port with variable latency.
- Buffers fetched instructions in a small queue and honours `Stall_F` and branch/jump redirects from the hazard and execute logic.
- Emits a NOP bubble whenever no fetched instruction is available.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `QDEPTH`, 2, instruction-queue depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  request valid; registered.
- `imem_addr`  out  32  word address; registered; bits [1:0] always 0.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle for the pending request.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req & imem_ack`.
- `Stall_F`  in  1  hold current output instruction; no pop.
- `Redirect`  in  1  taken branch/jump from execute.
- `Redirect_PC`  in  32  target address; bits [1:0] ignored and forced to 0.
- `PC_F`  out  32  PC of the head instruction.
- `PCPlus4_F`  out  32  `PC_F + 4`, modulo 2^32.
- `Instr_F`  out  32  head instruction, or NOP 32'h0000_0013 when the queue is empty.
- `Valid_F`  out  1  head is a real fetched instruction.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `pending`: one request outstanding.
  - `drop`: the outstanding response is stale.
  - Queue of `{pc, instr}` entries with count, read pointer and write pointer.
- Issue:
  - Raise `imem_req` with `imem_addr = fetch_pc` when `count + pending < QDEPTH`, counting a same-cycle pop as freeing a slot.
  - Only one request is outstanding at a time.
  - `imem_req` and `imem_addr` are held stable until `imem_ack`.
- Accept (`imem_req & imem_ack`):
  - If `drop` is 0: push `{imem_addr, imem_rdata}` and set `fetch_pc += 4`.
  - If `drop` is 1: discard the data and clear `drop`.
  - In the same cycle, re-issue back-to-back if space allows.
- Pop: when `Valid_F & ~Stall_F`, advance the read pointer.
- Empty queue: `Valid_F = 0`, `Instr_F = NOP`, `PC_F = fetch_pc`.
- Redirect (priority over `Stall_F`, pop and push):
  - Flush the queue.
  - Set `fetch_pc = {Redirect_PC[31:2], 2'b00}`.
  - If a request is pending and not acked this cycle, set `drop = 1`; `imem_req` stays high with the old address until its ack.
  - If the ack arrives in the redirect cycle, its data is discarded.
  - The first request to the target issues the cycle after the redirect, or the cycle after the stale ack.
- Wrap-around:
  - Queue pointers wrap modulo `QDEPTH`.
  - `fetch_pc` wraps modulo 2^32.
- Full queue: no request is issued, and an ack cannot occur because nothing is pending.
- Reset (any cycle, including mid-request):
  - `fetch_pc = RESET_PC`; `imem_req = 0`; `imem_addr = 0`.
  - `pending = 0`; `drop = 0`; queue empty.
  - Outputs: `Valid_F = 0`, `Instr_F = NOP`, `PC_F = RESET_PC`, `PCPlus4_F = RESET_PC + 4`.
  - An in-flight ack during reset is ignored.

## Timing
- First `imem_req` is high in the first cycle after `rst` deasserts.
- Output latency: data acked in cycle N appears on `Instr_F` with `Valid_F = 1` in cycle N+1.
- Throughput: one instruction per cycle with single-cycle ack and no stall.
- `PC_F`, `PCPlus4_F`, `Instr_F` and `Valid_F` are combinational from queue state only; there is no input-to-output combinational path.
- Redirect-to-valid penalty:
  - With an idle memory port and 1-cycle ack, 2 cycles after the redirect cycle.
  - Plus the stale-ack wait if a request was pending.

## Configuration
- `IF_FETCH_PERF_EN` defined:
  - Adds output `perf_fetched` (32, count of pushes).
  - Adds output `perf_dropped` (32, count of discarded acks plus entries flushed by redirect).
  - Adds output `perf_empty` (32, cycles with `Valid_F = 0` and `~Stall_F`).
  - All counters are zero on reset and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared pipeline package holds `NOP_INSTR` = 32'h0000_0013 and the `fetch_entry_t` struct `{pc[31:0], instr[31:0]}`.
- Sub-module `if_fetch_queue`: parameterised sync FIFO with push, pop, flush, count, and a head peek.
- Issue/drop control lives in the top module.

## Test plan
- **Reset and streaming:** 1-cycle ack, words A0..A3 at 0x0..0xC, no stall → `Valid_F` from cycle 2; `PC_F` = 0, 4, 8, C on consecutive cycles; `PCPlus4_F` = `PC_F + 4`.
- **Stall and backpressure:** `Stall_F` held 5 cycles with `QDEPTH = 2` → `PC_F` frozen; `imem_req` drops after 2 entries; stream resumes in order with no duplicates or gaps.
- **Redirect with a stale request:** redirect to 0x103 while a 3-cycle-latency request to 0x8 is pending → queue flushed; the 0x8 data is never output; next `imem_addr` = 0x100; `PC_F` = 0x100 first.
- **Simultaneous events:** redirect, ack and pop in the same cycle → acked data dropped; `fetch_pc` = target; `Valid_F = 0` next cycle; no underflow.
- **Empty bubble:** ack delayed 4 cycles → `Instr_F` = 0x00000013 and `Valid_F = 0` during the gap.
- **Reset mid-fetch:** `rst` asserted low during a pending request, with `imem_ack` arriving during reset → all outputs at reset values; the first post-reset request goes to `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: the NOP bubble encoding,
// the queued fetch entry layout, and small arithmetic helpers.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// if_fetch_queue: small synchronous FIFO of fetch entries with push, pop,
// flush, occupancy count and a peek at the head entry. DEPTH must be a power
// of two so the pointers wrap naturally.
module if_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output fetch_entry_t              head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // Next pointer/count/storage state; flush wins over push and pop.
  always_comb begin
    pop_ok   = pop & (count_q != '0);
    push_ok  = push & ((count_q != FULL) | pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage. Owns the fetch PC, drives a single-outstanding
// req/ack instruction port, queues returned words and presents the head (or a
// NOP bubble) to IF/ID. Redirects flush the queue and mark any in-flight
// response as stale.
// Optional build macro IF_FETCH_PERF_EN adds saturating perf counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Stall_F,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F,
  output logic [31:0] Instr_F,
  output logic        Valid_F
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_empty
`endif
);

  localparam int QCW = $clog2(QDEPTH) + 1;
  localparam logic [QCW-1:0] QFULL = QCW'(QDEPTH);

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    imem_addr_q, imem_addr_d;
  logic           imem_req_q, imem_req_d;
  logic           drop_q, drop_d;
  logic           accept, push, pop, still_pending;
  logic [QCW-1:0] q_count, q_count_next;
  fetch_entry_t   q_head, push_entry;

  if_fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (Redirect),
    .count     (q_count),
    .head      (q_head)
  );

  // Head presentation depends only on registered queue/PC state.
  always_comb begin
    Valid_F   = (q_count != '0);
    Instr_F   = Valid_F ? q_head.instr : NOP_INSTR;
    PC_F      = Valid_F ? q_head.pc : fetch_pc_q;
    PCPlus4_F = PC_F + 32'd4;
  end

  // Accept/push/pop decode, redirect handling and next request issue.
  always_comb begin
    accept        = imem_req_q & imem_ack;
    still_pending = imem_req_q & ~imem_ack;
    pop           = Valid_F & ~Stall_F & ~Redirect;
    push          = accept & ~drop_q & ~Redirect;
    push_entry    = '{pc: imem_addr_q, instr: imem_rdata};
    q_count_next  = Redirect ? '0 : (q_count + QCW'(push) - QCW'(pop));

    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (Redirect) begin
      fetch_pc_d = word_align(Redirect_PC);
      // A response still in flight belongs to the old path.
      drop_d     = still_pending;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (accept) begin
        drop_d = 1'b0;
      end
    end

    imem_req_d  = still_pending;
    imem_addr_d = imem_addr_q;
    if (!still_pending && (q_count_next < QFULL)) begin
      imem_req_d  = 1'b1;
      imem_addr_d = fetch_pc_d;
    end
  end

  // Fetch PC, request port and stale-response flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0;
      drop_q      <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      drop_q      <= drop_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] drop_inc;

  // Dropped work: discarded acks plus entries thrown away by a flush.
  always_comb begin
    drop_inc = 32'(accept & (drop_q | Redirect)) + (Redirect ? 32'(q_count) : 32'd0);
    perf_fetched_d = sat_add32(perf_fetched_q, 32'(push));
    perf_dropped_d = sat_add32(perf_dropped_q, drop_inc);
    perf_empty_d   = sat_add32(perf_empty_q, 32'(~Valid_F & ~Stall_F));
  end

  // Saturating counters, zeroed by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= 32'h0;
      perf_dropped_q <= 32'h0;
      perf_empty_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_empty_q   <= perf_empty_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_empty   = perf_empty_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized stall/redirect/ack/reset traffic, all checked
// every cycle against a queue-based reference model of the fetch rules.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Stall_F;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic [31:0] PC_F;
  logic [31:0] PCPlus4_F;
  logic [31:0] Instr_F;
  logic        Valid_F;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_empty;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Stall_F     (Stall_F),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .PC_F        (PC_F),
    .PCPlus4_F   (PCPlus4_F),
    .Instr_F     (Instr_F),
    .Valid_F     (Valid_F)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped),
    .perf_empty   (perf_empty)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: instruction queue of {pc, instr}, next fetch address,
  // one outstanding request (address), and whether its response is stale.
  logic [63:0] m_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_drop;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_q.delete();
    m_fpc  = RESET_PC;
    m_addr = 32'h0;
    m_pend = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic compare_model();
    bit          e_val;
    logic [31:0] e_pc, e_instr;
    e_val   = (m_q.size() != 0);
    e_pc    = e_val ? m_q[0][63:32] : m_fpc;
    e_instr = e_val ? m_q[0][31:0] : NOP;
    chk("model Valid_F", 32'(Valid_F), 32'(e_val));
    chk("model PC_F", PC_F, e_pc);
    chk("model PCPlus4_F", PCPlus4_F, e_pc + 32'd4);
    chk("model Instr_F", Instr_F, e_instr);
    chk("model imem_req", 32'(imem_req), 32'(m_pend));
    if (m_pend) chk("model imem_addr", imem_addr, m_addr);
  endtask

  task automatic model_step(input bit r, input bit st, input bit rd,
                            input logic [31:0] rpc, input bit ak);
    bit accept;
    if (!r) begin
      reset_model();
      return;
    end
    accept = m_pend && ak;
    if (rd) begin
      m_q.delete();
      m_fpc  = rpc & 32'hFFFF_FFFC;
      m_drop = m_pend && !accept;
    end else begin
      if (m_q.size() != 0 && !st) void'(m_q.pop_front());
      if (accept) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          m_q.push_back({m_addr, instr_of(m_addr)});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    if (accept) m_pend = 1'b0;
    if (!m_pend && m_q.size() < QDEPTH) begin
      m_pend = 1'b1;
      m_addr = m_fpc;
    end
  endtask

  // One cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input bit r, input bit st, input bit rd,
                      input logic [31:0] rpc, input bit ak);
    bit ak_eff;
    compare_model();
    ak_eff      = ak & (imem_req | ~r);
    rst         = r;
    Stall_F     = st;
    Redirect    = rd;
    Redirect_PC = rpc;
    imem_ack    = ak_eff;
    imem_rdata  = instr_of(imem_addr);
    model_step(r, st, rd, rpc, ak_eff);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b0; Stall_F = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset and streaming
    step(0, 0, 0, 0, 0);
    chk("reset Valid_F", 32'(Valid_F), 32'd0);
    chk("reset Instr_F", Instr_F, NOP);
    chk("reset PC_F", PC_F, RESET_PC);
    chk("reset PCPlus4_F", PCPlus4_F, RESET_PC + 32'd4);
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset imem_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0);
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1);
      chk("stream Valid_F", 32'(Valid_F), 32'd1);
      chk("stream PC_F", PC_F, 32'(4 * i));
      chk("stream PCPlus4_F", PCPlus4_F, 32'(4 * i + 4));
      chk("stream Instr_F", Instr_F, instr_of(32'(4 * i)));
    end

    // Stall and backpressure
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, 1);
      chk("stall PC_F", PC_F, 32'h0000_000C);
      chk("stall Valid_F", 32'(Valid_F), 32'd1);
      chk("stall imem_req", 32'(imem_req), 32'd0);
    end
    step(1, 0, 0, 0, 1);
    chk("resume PC_F", PC_F, 32'h0000_0010);
    chk("resume imem_req", 32'(imem_req), 32'd1);
    chk("resume imem_addr", imem_addr, 32'h0000_0014);
    step(1, 0, 0, 0, 1);
    chk("resume2 PC_F", PC_F, 32'h0000_0014);

    // Redirect with a stale request
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("pre-redirect addr", imem_addr, 32'h0000_0008);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0103, 0);
    chk("redir Valid_F", 32'(Valid_F), 32'd0);
    chk("redir PC_F", PC_F, 32'h0000_0100);
    chk("redir Instr_F", Instr_F, NOP);
    chk("redir held req", 32'(imem_req), 32'd1);
    chk("redir held addr", imem_addr, 32'h0000_0008);
    step(1, 0, 0, 0, 1);
    chk("post-stale addr", imem_addr, 32'h0000_0100);
    chk("post-stale Valid_F", 32'(Valid_F), 32'd0);
    step(1, 0, 0, 0, 1);
    chk("target Valid_F", 32'(Valid_F), 32'd1);
    chk("target PC_F", PC_F, 32'h0000_0100);
    chk("target Instr_F", Instr_F, instr_of(32'h0000_0100));

    // Simultaneous redirect, ack and pop
    step(1, 0, 1, 32'h0000_0200, 1);
    chk("simul Valid_F", 32'(Valid_F), 32'd0);
    chk("simul PC_F", PC_F, 32'h0000_0200);
    chk("simul imem_addr", imem_addr, 32'h0000_0200);
    step(1, 0, 0, 0, 1);
    chk("simul target PC_F", PC_F, 32'h0000_0200);
    chk("simul target Valid_F", 32'(Valid_F), 32'd1);

    // Empty bubble while ack is delayed
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      chk("bubble Valid_F", 32'(Valid_F), 32'd0);
      chk("bubble Instr_F", Instr_F, NOP);
    end
    step(1, 0, 0, 0, 1);
    chk("after bubble PC_F", PC_F, 32'h0000_0204);

    // Reset mid-fetch, ack arriving during reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("midrst Valid_F", 32'(Valid_F), 32'd0);
    chk("midrst Instr_F", Instr_F, NOP);
    chk("midrst PC_F", PC_F, RESET_PC);
    chk("midrst PCPlus4_F", PCPlus4_F, RESET_PC + 32'd4);
    chk("midrst imem_req", 32'(imem_req), 32'd0);
    chk("midrst imem_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0, 0);
    chk("postrst addr", imem_addr, RESET_PC);
    chk("postrst req", 32'(imem_req), 32'd1);

    // Randomized traffic, including redirects near the top of the address space
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 399) != 0),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 6),
           rpc,
           ($urandom_range(0, 99) < 55));
    end
    compare_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
